// File: rtl/uart_tx_fifo_if.sv
// Receiver-to-transmitter byte stream bundle with FIFO status.
// master = byte source / transmitter side, slave = buffer.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
);
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     tx_rdy;
  logic                     tx_en;
  logic [7:0]               tx_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;
  logic                     full;
  logic [CNT_W-1:0]         overflow_cnt;

  modport master (
    output in_valid,
    output in_data,
    output tx_rdy,
    input  tx_en,
    input  tx_data,
    input  count,
    input  empty,
    input  full,
    input  overflow_cnt
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  tx_rdy,
    output tx_en,
    output tx_data,
    output count,
    output empty,
    output full,
    output overflow_cnt
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between UART receiver and transmitter.
// Launches one byte per transmitter busy period; counts drops.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_ovf;
  logic             r_tx_en;
  logic [7:0]       r_tx_data;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));

  // A same-cycle pop frees the slot the push needs
  assign w_push = bus.in_valid && (!w_full || w_pop);
  assign w_drop = bus.in_valid && w_full && !w_pop;

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && bus.tx_rdy) begin
          w_pop  = 1'b1;
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!bus.tx_rdy) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (bus.tx_rdy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_tx_en <= w_pop;
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + CNT_W'(1);
    end
  end

  assign bus.tx_en        = r_tx_en;
  assign bus.tx_data      = r_tx_data;
  assign bus.count        = r_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.overflow_cnt = r_ovf;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model,
// per-cycle compare, directed scenarios plus random traffic.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // transmitter model: manual level, or busy 10 cycles after each tx_en
  logic auto_m  = 1'b0;
  logic man_rdy = 1'b1;
  int   bcnt    = 0;
  assign bus.tx_rdy = auto_m ? (bcnt == 0) : man_rdy;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_en === 1'b1) bcnt = 10;
      else if (bcnt > 0)      bcnt = bcnt - 1;
    end
  end

  // reference model
  logic [7:0]       mq[$];
  logic             m_en   = 1'b0;
  logic [7:0]       m_data = 8'h00;
  int               m_ovf  = 0;
  bit               need_low  = 1'b0;
  bit               need_high = 1'b0;
  int               cyc = 0;
  int               en_cyc[$];
  logic [7:0]       en_dat[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_en = 1'b0; m_data = 8'h00; m_ovf = 0;
        need_low = 1'b0; need_high = 1'b0;
      end else begin
        bit pop;
        int sz;
        sz  = mq.size();
        pop = !need_low && !need_high && (bus.tx_rdy === 1'b1) && (sz > 0);
        m_en = pop;
        if (pop) m_data = mq.pop_front();
        if (bus.in_valid) begin
          if (sz < DEPTH || pop) mq.push_back(bus.in_data);
          else if (m_ovf < (1 << CNT_W) - 1) m_ovf++;
        end
        // one launch, then transmitter must go busy and come back idle
        if (pop) begin
          need_low = 1'b1; need_high = 1'b1;
        end else if (need_low) begin
          if (!bus.tx_rdy) need_low = 1'b0;
        end else if (need_high) begin
          if (bus.tx_rdy) need_high = 1'b0;
        end
      end
      cyc++;
      @(negedge clk);
      chk("tx_en", 32'(bus.tx_en), 32'(m_en));
      chk("tx_data", 32'(bus.tx_data), 32'(m_data));
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("ovf", 32'(bus.overflow_cnt), 32'(m_ovf));
      if (bus.tx_en === 1'b1) begin
        en_cyc.push_back(cyc);
        en_dat.push_back(bus.tx_data);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic kick();
    man_rdy = 1'b0;
    tick();
    man_rdy = 1'b1;
    tick();
  endtask

  task automatic wait_pulses(int n, int budget, string nm);
    while (en_cyc.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    chk(nm, 32'(en_cyc.size() >= n), 32'd1);
  endtask

  initial begin
    int n0;
    int c0;
    logic [7:0] b3[3];
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_txen", 32'(bus.tx_en), 32'd0);
    chk("rst_txdata", 32'(bus.tx_data), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_cnt), 32'd0);

    // single byte latency
    man_rdy = 1'b1;
    n0 = en_cyc.size();
    c0 = cyc;
    push(8'h41);
    wait_pulses(n0 + 1, 10, "t1_wait");
    if (en_cyc.size() > n0) begin
      chk("t1_latency", 32'(en_cyc[n0] - c0), 32'd2);
      chk("t1_data", 32'(en_dat[n0]), 32'h41);
    end
    repeat (3) tick();
    chk("t1_empty", 32'(bus.empty), 32'd1);
    kick();

    // fill, overflow, drain in order
    man_rdy = 1'b0;
    n0 = en_cyc.size();
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    push(8'hAA);
    push(8'hBB);
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd16);
    chk("t2_ovf", 32'(bus.overflow_cnt), 32'd2);
    auto_m = 1'b1;
    wait_pulses(n0 + DEPTH, DEPTH * 15 + 50, "t2_wait");
    repeat (30) tick();
    chk("t2_npulse", 32'(en_cyc.size() - n0), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      if (n0 + i < en_dat.size())
        chk("t2_order", 32'(en_dat[n0 + i]), 32'(i));

    // paced transmitter, 3 back-to-back bytes
    n0 = en_cyc.size();
    for (int i = 0; i < 3; i++) begin
      b3[i] = 8'($urandom);
      push(b3[i]);
    end
    wait_pulses(n0 + 3, 80, "t3_wait");
    repeat (30) tick();
    chk("t3_npulse", 32'(en_cyc.size() - n0), 32'd3);
    if (en_cyc.size() >= n0 + 3) begin
      for (int i = 0; i < 3; i++)
        chk("t3_order", 32'(en_dat[n0 + i]), 32'(b3[i]));
      chk("t3_gap1", 32'(en_cyc[n0 + 1] - en_cyc[n0] >= 12), 32'd1);
      chk("t3_gap2", 32'(en_cyc[n0 + 2] - en_cyc[n0 + 1] >= 12), 32'd1);
    end

    // tx_rdy stuck high: single launch only
    auto_m = 1'b0;
    man_rdy = 1'b1;
    n0 = en_cyc.size();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (30) tick();
    chk("t4_npulse", 32'(en_cyc.size() - n0), 32'd1);
    chk("t4_count", 32'(bus.count), 32'd2);
    kick();
    auto_m = 1'b1;
    repeat (40) tick();
    chk("t4_drained", 32'(bus.count), 32'd0);

    // full FIFO, push coinciding with each pop, wraps pointers
    auto_m = 1'b0;
    man_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
    n0 = en_cyc.size();
    for (int i = 0; i < 40; i++) begin
      man_rdy = 1'b1;
      push(8'($urandom));
      man_rdy = 1'b0;
      tick();
      man_rdy = 1'b1;
      tick();
    end
    chk("t5_count", 32'(bus.count), 32'd16);
    chk("t5_ovf", 32'(bus.overflow_cnt), 32'd2);
    chk("t5_npulse", 32'(en_cyc.size() - n0), 32'd40);
    if (en_dat.size() > n0) chk("t5_first", 32'(en_dat[n0]), 32'h80);
    auto_m = 1'b1;
    repeat (DEPTH * 13 + 30) tick();
    chk("t5_drained", 32'(bus.count), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 3) == 0);
      bus.in_data  = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (DEPTH * 13 + 30) tick();
    chk("rand_drained", 32'(bus.count), 32'd0);

    // reset while busy with 5 queued
    auto_m = 1'b0;
    man_rdy = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    tick();
    tick();
    chk("t6_pre_count", 32'(bus.count), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_empty", 32'(bus.empty), 32'd1);
    chk("t6_txen", 32'(bus.tx_en), 32'd0);
    chk("t6_ovf", 32'(bus.overflow_cnt), 32'd0);
    man_rdy = 1'b1;
    n0 = en_cyc.size();
    push(8'h5A);
    wait_pulses(n0 + 1, 10, "t6_wait");
    if (en_dat.size() > n0) chk("t6_data", 32'(en_dat[n0]), 32'h5A);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer that sits between a UART receiver's valid/data output and a UART transmitter's en/rdy input. Without it, bytes that arrive while the transmitter is busy are lost. The block absorbs bursts on the forwarding paths (board-to-board and PC injection), drains them to the transmitter one byte at a time, and counts any bytes dropped on overflow.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two and at least 2.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  single-cycle strobe from the receiver: in_data is valid this cycle.
- in_data  input  8  received byte.
- tx_rdy  input  1  transmitter is idle and can accept a byte.
- tx_en  output  1  single-cycle launch strobe to the transmitter.
- tx_data  output  8  byte presented to the transmitter; registered.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow_cnt  output  CNT_W  number of dropped bytes; saturates.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All state updates on the posedge of clk.
- Reset values: tx_en=0, tx_data=8'h00, count=0, empty=1, full=0, overflow_cnt=0, rd/wr pointers=0, FSM=IDLE.
- Reset takes priority over every other event. A reset mid-transmission discards FIFO contents and returns the FSM to IDLE without waiting for tx_rdy.
- Storage: circular buffer, DEPTH x 8. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: on in_valid, in_data is written at wr_ptr and wr_ptr advances, if not full or if a pop occurs in the same cycle.
- Drop: on in_valid while full with no same-cycle pop, the byte is dropped. overflow_cnt increments by 1 and holds at 2^CNT_W-1. Pointers and count are unchanged.
- count: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- empty and full are decoded from the registered count; they are not separate state.
- Transmit FSM, three states:
  - IDLE: if !empty && tx_rdy, then in the same cycle: tx_en<=1, tx_data<=mem[rd_ptr], rd_ptr advances (pop), go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: tx_en<=0. If tx_rdy==0, go to BUSY; else stay in LAUNCH until the transmitter signals busy.
  - BUSY: wait for tx_rdy==1, then go to IDLE.
- tx_en is therefore a 1-cycle pulse, and at most one launch happens per transmitter busy period. A held-high tx_rdy can never cause a double launch.
- tx_data holds its value from the tx_en cycle until the next launch.
- Latency: a byte pushed into an empty FIFO with tx_rdy=1 appears on tx_en/tx_data 2 cycles after its in_valid cycle (the first cycle is the write, then IDLE sees !empty).
- A pop from IDLE may coincide with a push. FIFO order is preserved in all cases.
- No bypass path: every byte goes through storage.

Test Plan:
- Reset, then push 8'h41 with tx_rdy=1 -> tx_en pulses once exactly 2 cycles later with tx_data=8'h41; count returns to 0 and empty=1.
- Hold tx_rdy=0 and push DEPTH bytes 0..15, then push 8'hAA and 8'hBB -> full=1, count=16, overflow_cnt=2; after releasing tx_rdy, bytes 0..15 come out in order and AA/BB never appear.
- Model the transmitter with tx_rdy going low for 10 cycles after each tx_en, then push 3 bytes back-to-back -> exactly 3 tx_en pulses, each separated by at least 12 cycles, in order.
- Hold tx_rdy stuck at 1 (transmitter never goes busy) -> after one tx_en the FSM stays in LAUNCH and no second pulse appears, even with count>0.
- With the FIFO full, in_valid coincides with an IDLE pop -> byte accepted, count stays 16, overflow_cnt unchanged, wrap-around order correct over 40 bytes.
- Assert rst while in BUSY with count=5 -> next cycle count=0, empty=1, tx_en=0, overflow_cnt=0; a fresh push is then transmitted normally.
